// File: rtl/virtual_input_pkg.sv
// virtual_input_pkg: shared sizes, code values and FSM state type for the virtual-input link.
`default_nettype none

package virtual_input_pkg;

  localparam int NUM_SWITCHES = 18;
  localparam int NUM_BUTTONS  = 3;
  localparam int CODE_W       = 5;

  localparam logic [CODE_W-1:0] CODE_BTN0  = 5'd18;
  localparam logic [CODE_W-1:0] CODE_BTN1  = 5'd19;
  localparam logic [CODE_W-1:0] CODE_BTN2  = 5'd20;
  localparam logic [CODE_W-1:0] CODE_CLEAR = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } vi_state_t;

endpackage

`default_nettype wire

// File: rtl/vi_prio_enc.sv
// vi_prio_enc: lowest-set-bit encoder with a valid flag.
`default_nettype none

module vi_prio_enc #(
  parameter int WIDTH = 18,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/virtual_input_tx.sv
// virtual_input_tx: turns a target switch vector and button/clear requests into paced
// number/control codes, tracking the receiver's switch state in a shadow register.
`default_nettype none

module virtual_input_tx
  import virtual_input_pkg::*;
#(
  parameter int STROBE_CYCLES = 4,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SWITCHES-1:0] sw_target,
  input  logic [NUM_BUTTONS-1:0]  btn_req,
  input  logic                    clear_req,
  output logic [CODE_W-1:0]       number,
  output logic                    control,
  output logic [NUM_SWITCHES-1:0] sw_shadow,
  output logic                    busy
);

  localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_SWITCHES);

  vi_state_t                state;
  logic [CNT_W-1:0]         cnt;
  logic [NUM_BUTTONS-1:0]   btn_pend;
  logic                     clr_pend;

  logic [NUM_SWITCHES-1:0]  diff;
  logic [IDX_W-1:0]         sw_idx;
  logic                     sw_valid;
  logic [NUM_BUTTONS-1:0]   btn_eff;
  logic                     clr_eff;
  logic [CODE_W-1:0]        sel_code;
  logic [NUM_BUTTONS-1:0]   btn_take;
  logic                     clr_take;
  logic                     sw_take;
  logic                     work;
  logic                     load;
  logic [NUM_SWITCHES-1:0]  shadow_next;

  assign diff    = sw_target ^ sw_shadow;
  assign btn_eff = btn_pend | btn_req;
  assign clr_eff = clr_pend | clear_req;

  vi_prio_enc #(
    .WIDTH (NUM_SWITCHES),
    .IDX_W (IDX_W)
  ) u_sw_enc (
    .vec   (diff),
    .idx   (sw_idx),
    .valid (sw_valid)
  );

  always_comb begin
    sel_code = number;
    btn_take = '0;
    clr_take = 1'b0;
    sw_take  = 1'b0;
    if (clr_eff) begin
      sel_code = CODE_CLEAR;
      clr_take = 1'b1;
    end else if (sw_valid) begin
      sel_code = CODE_W'(sw_idx);
      sw_take  = 1'b1;
    end else begin
      casez (btn_eff)
        3'b??1: begin sel_code = CODE_BTN0; btn_take = 3'b001; end
        3'b?10: begin sel_code = CODE_BTN1; btn_take = 3'b010; end
        3'b100: begin sel_code = CODE_BTN2; btn_take = 3'b100; end
        default: ;
      endcase
    end
  end

  always_comb begin
    shadow_next = sw_shadow;
    if (clr_take)     shadow_next = '0;
    else if (sw_take) shadow_next = sw_shadow ^ (NUM_SWITCHES'(1) << sw_idx);
  end

  assign work = clr_eff | sw_valid | (|btn_eff);
  assign load = work && ((state == ST_IDLE) || (state == ST_GAP && cnt == '0));
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      number    <= '0;
      control   <= 1'b0;
      sw_shadow <= '0;
      btn_pend  <= '0;
      clr_pend  <= 1'b0;
    end else begin
      // A request coinciding with consumption of an already-pending bit stays pending.
      if (load) begin
        btn_pend  <= (btn_eff & ~btn_take) | (btn_pend & btn_req & btn_take);
        clr_pend  <= (clr_eff & ~clr_take) | (clr_pend & clear_req & clr_take);
        state     <= ST_STROBE;
        cnt       <= CNT_W'(STROBE_CYCLES - 1);
        number    <= sel_code;
        control   <= 1'b1;
        sw_shadow <= shadow_next;
      end else begin
        btn_pend <= btn_eff;
        clr_pend <= clr_eff;
        case (state)
          ST_STROBE: begin
            if (cnt == '0) begin
              state   <= ST_GAP;
              cnt     <= CNT_W'(GAP_CYCLES - 1);
              control <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
          ST_IDLE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_virtual_input_tx.sv
// tb_virtual_input_tx: directed vectors against hand-computed code sequences.
`default_nettype none

module tb_virtual_input_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] sw_target;
  logic [2:0]  btn_req;
  logic        clear_req;
  logic [4:0]  number;
  logic        control;
  logic [17:0] sw_shadow;
  logic        busy;

  logic        reset1;
  logic [17:0] sw_target1;
  logic [2:0]  btn_req1;
  logic        clear_req1;
  logic [4:0]  number1;
  logic        control1;
  logic [17:0] sw_shadow1;
  logic        busy1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  virtual_input_tx #(.STROBE_CYCLES(4), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw_target(sw_target), .btn_req(btn_req),
    .clear_req(clear_req), .number(number), .control(control),
    .sw_shadow(sw_shadow), .busy(busy)
  );

  virtual_input_tx #(.STROBE_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1), .sw_target(sw_target1), .btn_req(btn_req1),
    .clear_req(clear_req1), .number(number1), .control(control1),
    .sw_shadow(sw_shadow1), .busy(busy1)
  );

  // Code monitor for the 4/4 instance: records code at each rise plus high/low lengths.
  int codes[$];
  int highs[$];
  int gaps[$];
  int hi_len = 0;
  int lo_len = 0;
  int unstable = 0;
  logic prev_ctl = 1'b0;
  logic have_fall = 1'b0;
  logic [4:0] code_at_rise = '0;

  always @(negedge clk) begin
    if (control && !prev_ctl) begin
      codes.push_back(int'(number));
      if (have_fall) gaps.push_back(lo_len);
      hi_len = 1;
      code_at_rise = number;
    end else if (control) begin
      hi_len++;
      if (number != code_at_rise) unstable++;
    end else if (prev_ctl) begin
      highs.push_back(hi_len);
      lo_len = 1;
      have_fall = 1'b1;
    end else begin
      lo_len++;
    end
    prev_ctl = control;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_codes(input string tag, input int base, input int exp[$]);
    check({tag, "_ncodes"}, 32'(codes.size() - base), 32'(exp.size()));
    if (codes.size() - base == exp.size())
      for (int i = 0; i < exp.size(); i++)
        check($sformatf("%s_code%0d", tag, i), 32'(codes[base + i]), 32'(exp[i]));
  endtask

  initial begin
    int base;
    int hbase;
    int exp_ctl[6];
    int exp_num[6];

    reset = 1'b1; sw_target = '0; btn_req = '0; clear_req = 1'b0;
    reset1 = 1'b1; sw_target1 = '0; btn_req1 = '0; clear_req1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_number", 32'(number), 32'd0);
    check("rst_control", 32'(control), 32'd0);
    check("rst_shadow", 32'(sw_shadow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0; reset1 = 1'b0;
    @(negedge clk);

    // Two switch diffs, lowest bit first; one-edge latency from IDLE.
    base = codes.size(); hbase = highs.size();
    sw_target = 18'h00005;
    @(negedge clk);
    check("t1_lat_control", 32'(control), 32'd1);
    check("t1_lat_number", 32'(number), 32'd0);
    wait_idle("t1", 100);
    check_codes("t1", base, '{0, 2});
    check("t1_high0", 32'(highs[hbase]), 32'd4);
    check("t1_high1", 32'(highs[hbase + 1]), 32'd4);
    check("t1_gap0", 32'(gaps[0]), 32'd4);
    check("t1_shadow", 32'(sw_shadow), 32'h00005);

    // Button with simultaneous switch change: switch code goes first.
    base = codes.size();
    btn_req = 3'b010; sw_target = 18'h00004;
    @(negedge clk);
    btn_req = 3'b000;
    wait_idle("t2", 100);
    check_codes("t2", base, '{0, 19});
    check("t2_shadow", 32'(sw_shadow), 32'h00004);

    // Three presses of button0 during one strobe merge into a single code.
    base = codes.size();
    sw_target = 18'h00006;
    @(negedge clk);
    btn_req = 3'b001; @(negedge clk);
    btn_req = 3'b001; @(negedge clk);
    btn_req = 3'b001; @(negedge clk);
    btn_req = 3'b000;
    wait_idle("t3", 100);
    check_codes("t3", base, '{1, 18});
    check("t3_shadow", 32'(sw_shadow), 32'h00006);

    // Fill all switches, then clear with a new target.
    sw_target = 18'h3FFFF;
    @(negedge clk);
    wait_idle("t4a", 400);
    check("t4_full", 32'(sw_shadow), 32'h3FFFF);
    base = codes.size();
    clear_req = 1'b1; sw_target = 18'h20000;
    @(negedge clk);
    clear_req = 1'b0;
    wait_idle("t4", 100);
    check_codes("t4", base, '{31, 17});
    check("t4_shadow", 32'(sw_shadow), 32'h20000);
    check("t4_stable", 32'(unstable), 32'd0);

    // Reset during the second strobe cycle.
    sw_target = 18'h00000;
    @(negedge clk);
    check("t5_strobe", 32'(control), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_control", 32'(control), 32'd0);
    check("t5_number", 32'(number), 32'd0);
    check("t5_shadow", 32'(sw_shadow), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    base = codes.size();
    repeat (20) @(negedge clk);
    check("t5_nocodes", 32'(codes.size() - base), 32'd0);

    // 1/1 pacing: all three buttons, control toggling every cycle.
    exp_ctl = '{1, 0, 1, 0, 1, 0};
    exp_num = '{18, 18, 19, 19, 20, 20};
    btn_req1 = 3'b111;
    @(negedge clk);
    btn_req1 = 3'b000;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t6_ctl%0d", i), 32'(control1), 32'(exp_ctl[i]));
      check($sformatf("t6_num%0d", i), 32'(number1), 32'(exp_num[i]));
      @(negedge clk);
    end
    check("t6_busy", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
